spram_param: RTL and testbench

//  Parametrised single-port RAM: successor to the fixed 16x8 SPRAM. Adds configurable width/depth,

---
 rtl/spram_pkg.sv | 14 +
 rtl/spram_param_core.sv | 38 +++
 rtl/spram_param.sv | 137 +++++++++++++
 tb/tb_spram_param.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/spram_pkg.sv
// rtl/spram_pkg.sv - shared types and constants for the parametrised single-port RAM
package spram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int NO_CHANGE    = 0;
    localparam int WRITE_FIRST  = 1;
    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 2;

endpackage

// File: rtl/spram_param_core.sv
// rtl/spram_param_core.sv - bare DEPTH x DATA_W array, byte-enabled write, registered read
module spram_param_core #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] merged;

    always_comb begin
        merged = mem[idx];
        for (int b = 0; b < DATA_W/8; b++) begin
            if (be[b]) begin
                merged[8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end

    // A read issued together with a write returns the merged word (write-first view).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= merged;
        end
        if (rd_en) begin
            rdata <= wr_en ? merged : mem[idx];
        end
    end

endmodule

// File: rtl/spram_param.sv
// rtl/spram_param.sv - single-port RAM with clear walk, req/ready, range check and read latency pipe
module spram_param
    import spram_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int DEPTH      = 16,
    parameter int READ_LAT   = 1,
    parameter int WRITE_MODE = NO_CHANGE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [DATA_W-1:0]     data_in,
    output logic                  ready,
    output logic [DATA_W-1:0]     data_out,
    output logic                  rd_valid,
    output logic                  err
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

    if (DATA_W % 8 != 0 || DATA_W < 8) begin : g_bad_width
        $error("spram_param: DATA_W must be a non-zero multiple of 8");
    end
    if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_lat
        $error("spram_param: READ_LAT must be 1 or 2");
    end
    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
        $error("spram_param: DEPTH must be 1..2**ADDR_W");
    end

    state_t              state;
    logic [IDX_W-1:0]    clr_addr;
    logic                accept;
    logic                in_range;
    logic                returns_data;
    logic                wr_en;
    logic                rd_en;
    logic [IDX_W-1:0]    core_idx;
    logic [BE_W-1:0]     core_be;
    logic [DATA_W-1:0]   core_wdata;
    logic [DATA_W-1:0]   core_rdata;
    logic                v1;
    logic                z1;
    logic [DATA_W-1:0]   stage1_data;

    assign accept       = req & ready;
    assign in_range     = {1'b0, addr} < DEPTH_LIM;
    assign returns_data = accept & (~we | (WRITE_MODE == WRITE_FIRST));

    // The clear walk borrows the single write port until the last word is zeroed.
    assign wr_en      = ~reset & ((state == CLEAR) | (accept & we & in_range));
    assign rd_en      = ~reset & returns_data & in_range;
    assign core_idx   = (state == CLEAR) ? clr_addr : addr[IDX_W-1:0];
    assign core_be    = (state == CLEAR) ? {BE_W{1'b1}} : be;
    assign core_wdata = (state == CLEAR) ? '0 : data_in;

    spram_param_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_core (
        .clk    (clk),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .idx    (core_idx),
        .be     (core_be),
        .wdata  (core_wdata),
        .rdata  (core_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR;
            clr_addr <= '0;
            ready    <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == IDX_W'(DEPTH - 1)) begin
                        state <= READY;
                        ready <= 1'b1;
                    end
                end
                default: ready <= 1'b1;
            endcase
        end
    end

    // z1 remembers whether the most recent returned word was out of range and must read as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1  <= 1'b0;
            z1  <= 1'b1;
            err <= 1'b0;
        end else begin
            v1  <= returns_data;
            err <= accept & ~in_range;
            if (returns_data) begin
                z1 <= ~in_range;
            end
        end
    end

    assign stage1_data = z1 ? '0 : core_rdata;

    if (READ_LAT == 1) begin : g_lat1
        assign rd_valid = v1;
        assign data_out = stage1_data;
    end else begin : g_lat2
        logic              v2;
        logic [DATA_W-1:0] data_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                v2     <= 1'b0;
                data_q <= '0;
            end else begin
                v2 <= v1;
                if (v1) begin
                    data_q <= stage1_data;
                end
            end
        end

        assign rd_valid = v2;
        assign data_out = data_q;
    end

endmodule

// File: tb/tb_spram_param.sv
// tb/tb_spram_param.sv - four parameter variants on shared stimulus, checked against a behavioural model
module tb_spram_param;

    localparam int NI = 4;
    localparam int CW [NI] = '{32, 32, 8, 8};
    localparam int CD [NI] = '{16, 12, 16, 12};
    localparam int CL [NI] = '{1, 2, 1, 2};
    localparam int CM [NI] = '{0, 0, 1, 1};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  addr = '0;
    logic [3:0]  be = '0;
    logic [31:0] din = '0;

    logic [NI-1:0] rdy, rv, er;
    logic [31:0]   d0, d1;
    logic [7:0]    d2, d3;
    logic [31:0]   dout [NI];

    always #5 clk = ~clk;

    spram_param #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .READ_LAT(1), .WRITE_MODE(0)) u0 (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .be(be), .data_in(din),
        .ready(rdy[0]), .data_out(d0), .rd_valid(rv[0]), .err(er[0]));
    spram_param #(.DATA_W(32), .ADDR_W(4), .DEPTH(12), .READ_LAT(2), .WRITE_MODE(0)) u1 (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .be(be), .data_in(din),
        .ready(rdy[1]), .data_out(d1), .rd_valid(rv[1]), .err(er[1]));
    spram_param #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .READ_LAT(1), .WRITE_MODE(1)) u2 (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .be(be[0]), .data_in(din[7:0]),
        .ready(rdy[2]), .data_out(d2), .rd_valid(rv[2]), .err(er[2]));
    spram_param #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .READ_LAT(2), .WRITE_MODE(1)) u3 (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .be(be[0]), .data_in(din[7:0]),
        .ready(rdy[3]), .data_out(d3), .rd_valid(rv[3]), .err(er[3]));

    assign dout[0] = d0;
    assign dout[1] = d1;
    assign dout[2] = {24'h0, d2};
    assign dout[3] = {24'h0, d3};

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural reference: memory image, cycles since reset, and results due by edge number.
    logic [31:0] mm [NI][16];
    int          since [NI];
    bit          mready [NI];
    bit          due_v [NI][4];
    logic [31:0] due_d [NI][4];
    logic [31:0] edout [NI];
    bit          erv [NI];
    bit          eerr [NI];
    int          ecyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < NI; k++) begin
            logic [31:0] wmask, bmask, val;
            bit oor;
            if (reset) begin
                since[k]  = 0;
                mready[k] = 0;
                edout[k]  = '0;
                erv[k]    = 0;
                eerr[k]   = 0;
                for (int s = 0; s < 4; s++) due_v[k][s] = 0;
                continue;
            end
            wmask = (CW[k] == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
            bmask = '0;
            for (int b = 0; b < CW[k] / 8; b++) if (be[b]) bmask[8*b +: 8] = 8'hFF;
            eerr[k] = 0;
            if (req && mready[k]) begin
                oor = (int'(addr) >= CD[k]);
                if (we && !oor) mm[k][addr] = ((mm[k][addr] & ~bmask) | (din & bmask)) & wmask;
                if (!we || CM[k] == 1) begin
                    val = oor ? 32'h0 : mm[k][addr];
                    due_v[k][(ecyc + CL[k] - 1) % 4] = 1;
                    due_d[k][(ecyc + CL[k] - 1) % 4] = val;
                end
                eerr[k] = oor;
            end
            if (!mready[k]) begin
                since[k]++;
                if (since[k] == CD[k]) begin
                    mready[k] = 1;
                    for (int a = 0; a < 16; a++) mm[k][a] = '0;
                end
            end
            erv[k] = due_v[k][ecyc % 4];
            if (erv[k]) edout[k] = due_d[k][ecyc % 4];
            due_v[k][ecyc % 4] = 0;
        end
        ecyc++;
    endtask

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("u%0d.ready", k), 32'(rdy[k]), 32'(mready[k]));
            chk($sformatf("u%0d.rd_valid", k), 32'(rv[k]), 32'(erv[k]));
            chk($sformatf("u%0d.err", k), 32'(er[k]), 32'(eerr[k]));
            chk($sformatf("u%0d.data_out", k), dout[k], edout[k]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input bit r, input bit w, input logic [3:0] a, input logic [3:0] e,
                         input logic [31:0] d);
        req = r; we = w; addr = a; be = e; din = d;
    endtask

    typedef struct {
        bit          w;
        logic [3:0]  a;
        logic [3:0]  e;
        logic [31:0] d;
        bit          exp_rv0;
        logic [31:0] exp_d0;
        bit          exp_err1;
    } vec_t;

    vec_t vt [12];

    initial begin
        int t0, t1;
        vt[0]  = '{1'b1, 4'd3,  4'hF, 32'h0000_00A5, 1'b0, 32'h0,          1'b0};
        vt[1]  = '{1'b0, 4'd3,  4'hF, 32'h0,         1'b1, 32'h0000_00A5,  1'b0};
        vt[2]  = '{1'b1, 4'd5,  4'hF, 32'h1122_3344, 1'b0, 32'h0000_00A5,  1'b0};
        vt[3]  = '{1'b1, 4'd5,  4'h5, 32'hAABB_CCDD, 1'b0, 32'h0000_00A5,  1'b0};
        vt[4]  = '{1'b0, 4'd5,  4'h0, 32'h0,         1'b1, 32'h11BB_33DD,  1'b0};
        vt[5]  = '{1'b0, 4'd0,  4'h0, 32'h0,         1'b1, 32'h0,          1'b0};
        vt[6]  = '{1'b1, 4'd5,  4'h0, 32'hDEAD_BEEF, 1'b0, 32'h0,          1'b0};
        vt[7]  = '{1'b0, 4'd5,  4'h0, 32'h0,         1'b1, 32'h11BB_33DD,  1'b0};
        vt[8]  = '{1'b1, 4'd13, 4'hF, 32'h0000_0055, 1'b0, 32'h11BB_33DD,  1'b1};
        vt[9]  = '{1'b0, 4'd13, 4'h0, 32'h0,         1'b1, 32'h0000_0055,  1'b1};
        vt[10] = '{1'b0, 4'd11, 4'h0, 32'h0,         1'b1, 32'h0,          1'b0};
        vt[11] = '{1'b1, 4'd2,  4'hF, 32'h0000_005A, 1'b0, 32'h0,          1'b0};

        // Reset, then measure how many cycles each depth takes to come ready.
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1'b1, 1'b0, 4'd0, 4'h0, 32'h0);
        t0 = 0; t1 = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (rdy[0] && t0 == 0) t0 = i;
            if (rdy[1] && t1 == 0) t1 = i;
        end
        chk("ready_latency_depth16", 32'(t0), 32'd16);
        chk("ready_latency_depth12", 32'(t1), 32'd12);

        for (int a = 0; a < 16; a++) begin
            drive(1'b1, 1'b0, 4'(a), 4'h0, 32'h0);
            step();
            chk("cleared_read", d0, 32'h0);
        end

        for (int i = 0; i < 12; i++) begin
            drive(1'b1, vt[i].w, vt[i].a, vt[i].e, vt[i].d);
            step();
            chk($sformatf("vec%0d.rd_valid", i), 32'(rv[0]), 32'(vt[i].exp_rv0));
            chk($sformatf("vec%0d.data_out", i), d0, vt[i].exp_d0);
            chk($sformatf("vec%0d.err_d12", i), 32'(er[1]), 32'(vt[i].exp_err1));
        end
        drive(1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
        step();
        step();

        // Reset lands while a latency-2 read is still in flight.
        drive(1'b1, 1'b1, 4'd3, 4'hF, 32'h0000_0077);
        step();
        drive(1'b1, 1'b0, 4'd3, 4'h0, 32'h0);
        step();
        drive(1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
        reset = 1'b1;
        step();
        chk("inflight_lat2_dropped", 32'(rv[1]), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("ready_low_after_reset", 32'(rdy[0]), (i == 15) ? 32'd1 : 32'd0);
        end
        drive(1'b1, 1'b0, 4'd3, 4'h0, 32'h0);
        step();
        chk("reread_after_reset", d0, 32'h0);
        drive(1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
        step();
        step();

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 399) == 0);
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
                  4'($urandom), $urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
